fir_mac_sched: RTL and testbench
================================

Name: fir_mac_sched

Overview:
Time-multiplexed FIR controller. It accepts one sample per valid/ready handshake and stores it in a circular delay line. It then sequences NTAPS multiply-accumulate steps through a single shared multiplier, and presents the scaled, saturated result on an output valid/ready port. Coefficients are held in an internal register file that is written over a simple config port. It sits between the sample source and the downstream consumer, in place of a fully parallel FIR.

Parameters:
DW, 8, sample and output width (signed two's complement)
CW, 8, coefficient width (signed)
NTAPS, 4, number of taps (>=2)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_x  in  DW  input sample
i_valid  in  1  sample valid
o_ready  out  1  controller can accept a sample
o_y  out  DW  filtered output sample
o_valid  out  1  o_y valid
i_ready  in  1  downstream accepts o_y
i_cw_en  in  1  coefficient write strobe
i_cw_addr  in  clog2(NTAPS)  coefficient index
i_cw_data  in  CW  coefficient value
o_cw_drop  out  1  one-cycle pulse: write rejected

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - Delay line, coefficients, accumulator and tap counter are all 0.
  - o_valid=0, o_ready=0 while rst is high, o_y=0, o_cw_drop=0.
  - o_ready rises the first cycle after rst deasserts.
- Accumulator width is AW=DW+CW+clog2(NTAPS). Products are full-precision signed. There is no internal overflow.
- States: IDLE, MAC, OUT.
- IDLE:
  - o_ready=1.
  - i_valid&o_ready at an edge: i_x is written to line[wr_ptr], wr_ptr advances (mod NTAPS), acc<=0, tap<=0, next state MAC.
- MAC:
  - One tap per cycle: acc += line[newest-k]*coef[k], with newest = the sample just written and the index taken modulo NTAPS.
  - The tap counter runs 0..NTAPS-1. After tap NTAPS-1, next state OUT.
  - o_ready=0.
- OUT:
  - o_valid=1 and o_y = sat_DW(acc >>> SHIFT), where sat clamps to [-2^(DW-1), 2^(DW-1)-1].
  - o_y and o_valid stay stable until i_ready=1 at an edge, then next state IDLE.
  - o_ready=0.
- Latency: a sample accepted at edge t gives o_valid high from edge t+NTAPS+1.
- Throughput: with i_ready held high, one sample every NTAPS+2 cycles.
- Coefficient writes:
  - Accepted only in IDLE with i_cw_addr<NTAPS: coef[addr]<=i_cw_data at that edge.
  - Otherwise (MAC, OUT, or address out of range) the write is discarded and o_cw_drop pulses high for the next cycle.
- Simultaneous sample accept and coefficient write in IDLE: both take effect, and the computation for that sample uses the new coefficient.
- i_valid outside IDLE is ignored. The sample is not captured, and the source must hold it until o_ready.
- Reset mid-MAC or mid-OUT: the result is abandoned, o_valid drops asynchronously, and the delay line is cleared.
- Before NTAPS samples have arrived, the unfilled line entries are 0 (zero-padded start).

Decomposition:
- Shared package fir_pkg holds:
  - the state encoding (IDLE/MAC/OUT);
  - the AW width function;
  - the saturation constants for DW.
- One sub-module, fir_mac_unit:
  - signed multiply plus accumulate register, with clear and enable inputs;
  - the controller drives its operands and controls.
- The controller owns the FSM, pointers, delay line, coefficient file and output register.

Test Plan:
- Moving sum, default parameters, coef={1,1,1,1}, i_x=1,2,3,4,5 with i_ready=1: o_y=1,3,6,10,14; each o_valid appears 5 cycles after its accept.
- Saturation with coef all 127: four samples of 127 -> final o_y=127. Then coef all 127 with four samples of -128 -> final o_y=-128.
- Backpressure: hold i_ready=0 for 6 cycles in OUT: o_y and o_valid stay stable, o_ready=0, and a pulsed i_valid with i_x=9 is not captured.
- Coefficient write during MAC (addr 0, data 5): o_cw_drop pulses once and coef[0] is unchanged. A write with addr>=NTAPS in IDLE is also dropped.
- Simultaneous accept and write coef[0]=2 with i_x=3 after reset: o_y=6.
- Reset asserted mid-MAC: o_valid=0 immediately. After release, i_x=4 with coef={1,1,1,1} gives o_y=4 (history cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR controller.
// Holds the FSM state encoding, the accumulator width rule and the output saturation limits.
// No logic of its own; imported by fir_mac_unit and fir_mac_sched.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Full-precision sum of ntaps products of dw x cw signed operands.
  function automatic int fir_aw(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Largest value representable in a dw-bit signed output.
  function automatic longint sat_hi(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  // Smallest value representable in a dw-bit signed output.
  function automatic longint sat_lo(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiplier feeding an accumulate register.
// Latency: acc reflects a*b one clock after en; clr zeroes acc on the next clock.
// Backpressure: none, the controller sequences clr/en.
// Ports: clk, rst (async, active high), clr, en, a (DW signed), b (CW signed), acc (AW signed).
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] acc
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0] prod;

  // Operands are sign-extended to the product width so the multiply is full precision.
  assign prod = PW'(a) * PW'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR: one sample in, NTAPS MAC cycles through a shared multiplier, one saturated sample out.
// Latency: sample accepted at edge t is presented with o_valid sampled high at edge t+NTAPS+1.
// Backpressure: o_y/o_valid hold until i_ready; o_ready stays low from accept until the result is taken.
// Ports: clk, rst, i_x/i_valid/o_ready (sample in), o_y/o_valid/i_ready (result out),
//        i_cw_en/i_cw_addr/i_cw_data (coefficient write, IDLE only), o_cw_drop (rejected-write pulse).
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int NTAPS = 4,
  parameter int SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DW-1:0]        i_x,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [DW-1:0]        o_y,
  output logic                        o_valid,
  input  logic                        i_ready,
  input  logic                        i_cw_en,
  input  logic [$clog2(NTAPS)-1:0]    i_cw_addr,
  input  logic signed [CW-1:0]        i_cw_data,
  output logic                        o_cw_drop
);

  localparam int AW = fir_aw(DW, CW, NTAPS);
  localparam int AB = $clog2(NTAPS);
  localparam logic [AB:0]            NT   = (AB + 1)'(NTAPS);
  localparam logic [AB-1:0]          LAST = AB'(NTAPS - 1);
  localparam logic signed [AW-1:0]   Y_HI = AW'(sat_hi(DW));
  localparam logic signed [AW-1:0]   Y_LO = AW'(sat_lo(DW));

  state_t state, nxt;

  logic signed [DW-1:0] dly  [NTAPS];
  logic signed [CW-1:0] coef [NTAPS];
  logic [AB-1:0]        wr_ptr;
  logic [AB-1:0]        rd_ptr;
  logic [AB-1:0]        tap;
  logic                 run;
  logic                 cw_drop;
  logic                 accept;
  logic                 last_tap;
  logic                 cw_ok;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sh;
  logic signed [DW-1:0] y_sat;

  function automatic logic [AB-1:0] ptr_inc(input logic [AB-1:0] p);
    return (p == LAST) ? '0 : p + AB'(1);
  endfunction

  function automatic logic [AB-1:0] ptr_dec(input logic [AB-1:0] p);
    return (p == '0) ? LAST : p - AB'(1);
  endfunction

  assign accept   = i_valid & o_ready;
  assign last_tap = (tap == LAST);
  assign cw_ok    = i_cw_en & (state == S_IDLE) & ({1'b0, i_cw_addr} < NT);

  // rd_ptr walks backwards from the newest sample while tap walks forward
  // through the coefficients, giving line[newest-k]*coef[k] without a modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tap     <= '0;
      run     <= 1'b0;
      cw_drop <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dly[i]  <= '0;
        coef[i] <= '0;
      end
    end else begin
      run     <= 1'b1;
      cw_drop <= i_cw_en & ~cw_ok;
      if (cw_ok) begin
        coef[i_cw_addr] <= i_cw_data;
      end
      if (accept) begin
        dly[wr_ptr] <= i_x;
        wr_ptr      <= ptr_inc(wr_ptr);
        rd_ptr      <= wr_ptr;
        tap         <= '0;
      end else if (state == S_MAC) begin
        rd_ptr <= ptr_dec(rd_ptr);
        tap    <= last_tap ? '0 : tap + AB'(1);
      end
    end
  end

  fir_mac_unit #(
    .DW (DW),
    .CW (CW),
    .AW (AW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == S_MAC),
    .a   (dly[rd_ptr]),
    .b   (coef[tap]),
    .acc (acc)
  );

  always_comb begin
    acc_sh = acc >>> SHIFT;
    if (acc_sh > Y_HI) begin
      y_sat = Y_HI[DW-1:0];
    end else if (acc_sh < Y_LO) begin
      y_sat = Y_LO[DW-1:0];
    end else begin
      y_sat = acc_sh[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept)   nxt = S_MAC;
      S_MAC:   if (last_tap) nxt = S_OUT;
      S_OUT:   if (i_ready)  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // run keeps o_ready low while reset is held and for the release cycle.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_y     = '0;
    case (state)
      S_IDLE: o_ready = run;
      S_OUT: begin
        o_valid = 1'b1;
        o_y     = y_sat;
      end
      default: ;
    endcase
  end

  assign o_cw_drop = cw_drop;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: scoreboard of expected outputs from a convolution model.
// Latency: checks first-valid timing per sample against the accept cycle.
// Backpressure: exercises held, random and always-ready consumers.
module tb_fir_mac_sched;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int NTAPS = 4;
  localparam int SHIFT = 0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] i_x = '0;
  logic                 i_valid = 1'b0;
  logic                 i_ready = 1'b1;
  logic                 i_cw_en = 1'b0;
  logic [1:0]           i_cw_addr = '0;
  logic signed [CW-1:0] i_cw_data = '0;
  logic                 o_ready;
  logic                 o_valid;
  logic                 o_cw_drop;
  logic signed [DW-1:0] o_y;

  // Three-tap instance, used only for the out-of-range address check.
  logic signed [DW-1:0] x3 = '0;
  logic                 v3_in = 1'b0;
  logic                 r3_in = 1'b1;
  logic                 c3_en = 1'b0;
  logic [1:0]           c3_addr = '0;
  logic signed [CW-1:0] c3_data = '0;
  logic                 r3, v3, d3;
  logic signed [DW-1:0] y3;

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   hist[$];
  int   coef_m[NTAPS];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;
  bit   prev_v = 1'b0;

  fir_mac_sched #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .i_x(i_x), .i_valid(i_valid), .o_ready(o_ready),
    .o_y(o_y), .o_valid(o_valid), .i_ready(i_ready), .i_cw_en(i_cw_en),
    .i_cw_addr(i_cw_addr), .i_cw_data(i_cw_data), .o_cw_drop(o_cw_drop)
  );

  fir_mac_sched #(.DW(DW), .CW(CW), .NTAPS(3), .SHIFT(0)) dut3 (
    .clk(clk), .rst(rst), .i_x(x3), .i_valid(v3_in), .o_ready(r3),
    .o_y(y3), .o_valid(v3), .i_ready(r3_in), .i_cw_en(c3_en),
    .i_cw_addr(c3_addr), .i_cw_data(c3_data), .o_cw_drop(d3)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Direct convolution over the samples seen since reset, newest first.
  function automatic int model_y();
    longint s  = 0;
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    longint lo = -(hi + 1);
    for (int k = 0; k < NTAPS; k++) begin
      if (k < hist.size()) s += longint'(coef_m[k]) * longint'(hist[k]);
    end
    s = s >>> SHIFT;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return int'(s);
  endfunction

  // Monitor: compares every presented output against the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (o_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: o_y=%0d with nothing expected (cycle %0d)", o_y, cyc);
        end else begin
          if (!prev_v) chk("latency", cyc - q[0].cyc, NTAPS + 1);
          chk("o_y", o_y, q[0].y);
          chk("o_ready_in_out", o_ready, 0);
          if (i_ready) void'(q.pop_front());
        end
      end
      prev_v = o_valid;
    end
  end

  task automatic send(input int x, input bit w = 1'b0, input int a = 0, input int d = 0);
    int n = 0;
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_x     = DW'(x);
    if (w) begin
      i_cw_en   = 1'b1;
      i_cw_addr = 2'(a);
      i_cw_data = CW'(d);
    end
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: o_ready=%0d expected 1 within 100 cycles", o_ready);
        break;
      end
    end
    if (n <= 100) begin
      if (w) coef_m[a] = d;
      hist.push_front(x);
      if (hist.size() > NTAPS) void'(hist.pop_back());
      q.push_back('{model_y(), cyc});
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_cw_en = 1'b0;
  endtask

  task automatic cw(input int a, input int d, input bit exp_drop);
    @(posedge clk);
    #1;
    i_cw_en   = 1'b1;
    i_cw_addr = 2'(a);
    i_cw_data = CW'(d);
    @(posedge clk);
    #1;
    i_cw_en = 1'b0;
    @(negedge clk);
    chk("cw_drop", o_cw_drop, exp_drop);
    @(negedge clk);
    chk("cw_drop_pulse_end", o_cw_drop, 0);
    if (!exp_drop) coef_m[a] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (o_ready && q.size() == 0) break;
      n++;
      if (n > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: o_ready=%0d pending=%0d, expected 1 and 0", o_ready, q.size());
        break;
      end
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    forever begin
      @(negedge clk);
      if (o_valid) break;
      n++;
      if (n > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid_timeout: o_valid=%0d expected 1 within 50 cycles", o_valid);
        break;
      end
    end
  endtask

  task automatic set_coefs(input int c);
    wait_idle();
    for (int k = 0; k < NTAPS; k++) cw(k, c, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_cw_en = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 0);
    chk("rst_o_y", o_y, 0);
    q.delete();
    hist.delete();
    for (int k = 0; k < NTAPS; k++) coef_m[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_o_ready", o_ready, 1);
    chk("post_rst_cw_drop", o_cw_drop, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_o_valid", o_valid, 0);
    chk("init_o_ready", o_ready, 0);
    chk("init_o_y", o_y, 0);
    chk("init_cw_drop", o_cw_drop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("first_o_ready", o_ready, 1);

    // Moving sum over 1..5.
    set_coefs(1);
    rdy_mode = 0;
    for (int x = 1; x <= 5; x++) send(x);
    wait_idle();

    // Saturation at both rails.
    set_coefs(127);
    repeat (4) send(127);
    wait_idle();
    repeat (4) send(-128);
    wait_idle();

    // Stalled consumer: output holds, a pulsed sample of 9 is ignored.
    set_coefs(1);
    rdy_mode = 2;
    send(11);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      i_valid = (i == 2);
      i_x     = DW'(9);
      @(negedge clk);
      chk("stall_o_valid", o_valid, 1);
      chk("stall_o_ready", o_ready, 0);
    end
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    rdy_mode = 0;
    wait_idle();
    send(1);
    wait_idle();

    // Coefficient write during MAC is rejected; coef[0] stays 1.
    send(2);
    cw(0, 5, 1'b1);
    wait_idle();
    send(3);
    wait_idle();

    // Sample accept and coefficient write in the same cycle.
    do_reset();
    wait_idle();
    send(3, 1'b1, 0, 2);
    wait_idle();

    // Reset in the middle of MAC clears the history.
    set_coefs(1);
    send(7);
    do_reset();
    set_coefs(1);
    send(4);
    wait_idle();

    // Reset while holding a result.
    rdy_mode = 2;
    send(6);
    wait_valid();
    do_reset();
    rdy_mode = 0;

    // Address beyond the tap count on the three-tap instance.
    @(posedge clk);
    #1;
    c3_en   = 1'b1;
    c3_addr = 2'd3;
    c3_data = 8'sd5;
    @(posedge clk);
    #1;
    c3_en = 1'b0;
    @(negedge clk);
    chk("cw_drop_addr_range", d3, 1);
    @(posedge clk);
    #1;
    c3_en   = 1'b1;
    c3_addr = 2'd2;
    @(posedge clk);
    #1;
    c3_en = 1'b0;
    @(negedge clk);
    chk("cw_ok_addr_in_range", d3, 0);

    // Randomized traffic with a random consumer and occasional coefficient updates.
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      int x;
      x = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        cw(int'($urandom_range(0, NTAPS - 1)), int'($urandom_range(0, 255)) - 128, 1'b0);
      end
      if ($urandom_range(0, 4) == 0) begin
        wait_idle();
        send(x, 1'b1, int'($urandom_range(0, NTAPS - 1)), int'($urandom_range(0, 255)) - 128);
      end else begin
        send(x);
      end
    end
    wait_idle();
    rdy_mode = 0;
    chk("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
